// File: rtl/regfile_mp.sv
`default_nettype none
// regfile_mp: dual-write / dual-read register file with write-through bypass and an
// optional busy scoreboard enabled by REGFILE_SCOREBOARD_EN.  Rev 1.0
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we_0,
    input  logic [ADDR_W-1:0] waddr_0,
    input  logic [DATA_W-1:0] wdata_0,
    input  logic              we_1,
    input  logic [ADDR_W-1:0] waddr_1,
    input  logic [DATA_W-1:0] wdata_1,
    input  logic [ADDR_W-1:0] raddr_1,
    input  logic [ADDR_W-1:0] raddr_2,
    output logic [DATA_W-1:0] rdata_1,
    output logic [DATA_W-1:0] rdata_2,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic              busy_1,
    output logic              busy_2
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              w_acc_0;
    logic              w_acc_1;

    // A write to the hardwired zero register is dropped entirely, including for bypass.
    assign w_acc_0 = we_0 && !((ZERO_REG != 0) && (waddr_0 == '0));
    assign w_acc_1 = we_1 && !((ZERO_REG != 0) && (waddr_1 == '0));

    // Port 1 is written last so it wins an address collision.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_acc_0) r_mem[waddr_0] <= wdata_0;
            if (w_acc_1) r_mem[waddr_1] <= wdata_1;
        end
    end

`ifdef REGFILE_SCOREBOARD_EN
    logic [DEPTH-1:0] r_busy;
    logic             w_rsv;

    assign w_rsv = rsv_en && !((ZERO_REG != 0) && (rsv_addr == '0));

    // Reservation is applied after the releases so a same-cycle set keeps the bit high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_busy <= '0;
        end else begin
            if (w_acc_0) r_busy[waddr_0] <= 1'b0;
            if (w_acc_1) r_busy[waddr_1] <= 1'b0;
            if (w_rsv)   r_busy[rsv_addr] <= 1'b1;
        end
    end
`else
    logic w_unused_rsv;
    assign w_unused_rsv = ^{rsv_en, rsv_addr};
`endif

    for (genvar gi = 0; gi < 2; gi++) begin : g_rd
        logic [ADDR_W-1:0] w_a;
        logic [DATA_W-1:0] w_rd;
        logic              w_bz;
        logic              w_zero;
        logic              w_hit_0;
        logic              w_hit_1;

        assign w_a     = (gi == 0) ? raddr_1 : raddr_2;
        assign w_zero  = (ZERO_REG != 0) && (w_a == '0);
        assign w_hit_0 = (BYPASS != 0) && w_acc_0 && (waddr_0 == w_a);
        assign w_hit_1 = (BYPASS != 0) && w_acc_1 && (waddr_1 == w_a);

        always_comb begin
            w_rd = r_mem[w_a];
            if (w_hit_0) w_rd = wdata_0;
            if (w_hit_1) w_rd = wdata_1;
            if (w_zero || !reset) w_rd = '0;
        end

`ifdef REGFILE_SCOREBOARD_EN
        // A retiring producer hides the busy bit unless a new producer issues this cycle.
        always_comb begin
            w_bz = r_busy[w_a];
            if ((w_hit_0 || w_hit_1) && !(rsv_en && (rsv_addr == w_a))) w_bz = 1'b0;
            if (w_zero || !reset) w_bz = 1'b0;
        end
`else
        assign w_bz = 1'b0;
`endif
    end

    assign rdata_1 = g_rd[0].w_rd;
    assign rdata_2 = g_rd[1].w_rd;
    assign busy_1  = g_rd[0].w_bz;
    assign busy_2  = g_rd[1].w_bz;

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// tb_regfile_mp: randomized + directed scoreboard bench for two regfile_mp configurations.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        we_0 = 1'b0, we_1 = 1'b0, rsv_en = 1'b0;
    logic [4:0]  waddr_0 = '0, waddr_1 = '0, raddr_1 = '0, raddr_2 = '0, rsv_addr = '0;
    logic [31:0] wdata_0 = '0, wdata_1 = '0;

    logic [31:0] a_rd1, a_rd2, b_rd1, b_rd2;
    logic        a_bz1, a_bz2, b_bz1, b_bz2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_mp u_a (
        .clk(clk), .reset(reset),
        .we_0(we_0), .waddr_0(waddr_0), .wdata_0(wdata_0),
        .we_1(we_1), .waddr_1(waddr_1), .wdata_1(wdata_1),
        .raddr_1(raddr_1), .raddr_2(raddr_2), .rdata_1(a_rd1), .rdata_2(a_rd2),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_1(a_bz1), .busy_2(a_bz2)
    );

    regfile_mp #(.ZERO_REG(0), .BYPASS(0)) u_b (
        .clk(clk), .reset(reset),
        .we_0(we_0), .waddr_0(waddr_0), .wdata_0(wdata_0),
        .we_1(we_1), .waddr_1(waddr_1), .wdata_1(wdata_1),
        .raddr_1(raddr_1), .raddr_2(raddr_2), .rdata_1(b_rd1), .rdata_2(b_rd2),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_1(b_bz1), .busy_2(b_bz2)
    );

    // Reference state: index 0 = zero-reg/bypass config, index 1 = plain config.
    logic [31:0] mem  [2][32];
    bit          busy [2][32];

    typedef struct {
        logic [31:0] a1, a2, b1, b2;
        logic        abz1, abz2, bbz1, bbz2;
    } exp_t;
    exp_t q[$];

    function automatic bit accepted(input int k, input logic we, input logic [4:0] a);
        return we && !(k == 0 && a == 5'd0);
    endfunction

    function automatic logic [31:0] exp_rd(input int k, input logic [4:0] a);
        if (!reset) return 32'd0;
        if (k == 0 && a == 5'd0) return 32'd0;
        if (k == 0 && accepted(k, we_1, waddr_1) && waddr_1 == a) return wdata_1;
        if (k == 0 && accepted(k, we_0, waddr_0) && waddr_0 == a) return wdata_0;
        return mem[k][a];
    endfunction

    function automatic logic exp_bz(input int k, input logic [4:0] a);
`ifdef REGFILE_SCOREBOARD_EN
        bit wr_hit;
        if (!reset) return 1'b0;
        if (k == 0 && a == 5'd0) return 1'b0;
        wr_hit = (accepted(k, we_0, waddr_0) && waddr_0 == a) ||
                 (accepted(k, we_1, waddr_1) && waddr_1 == a);
        if (k == 0 && wr_hit && !(rsv_en && rsv_addr == a)) return 1'b0;
        return busy[k][a];
`else
        return 1'b0;
`endif
    endfunction

    task automatic clear_model();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 32; i++) begin
                mem[k][i]  = 32'd0;
                busy[k][i] = 1'b0;
            end
    endtask

    task automatic commit_edge();
        for (int k = 0; k < 2; k++) begin
            bit a0, a1;
            a0 = accepted(k, we_0, waddr_0);
            a1 = accepted(k, we_1, waddr_1);
            if (a0) begin mem[k][waddr_0] = wdata_0; busy[k][waddr_0] = 1'b0; end
            if (a1) begin mem[k][waddr_1] = wdata_1; busy[k][waddr_1] = 1'b0; end
            if (rsv_en && !(k == 0 && rsv_addr == 5'd0)) busy[k][rsv_addr] = 1'b1;
        end
    endtask

    // One cycle: inputs already set, predict outputs, let the edge happen, update the model.
    task automatic step();
        exp_t e;
        if (!reset) clear_model();
        e.a1 = exp_rd(0, raddr_1);  e.a2 = exp_rd(0, raddr_2);
        e.b1 = exp_rd(1, raddr_1);  e.b2 = exp_rd(1, raddr_2);
        e.abz1 = exp_bz(0, raddr_1); e.abz2 = exp_bz(0, raddr_2);
        e.bbz1 = exp_bz(1, raddr_1); e.bbz2 = exp_bz(1, raddr_2);
        q.push_back(e);
        @(posedge clk);
        if (reset) commit_edge();
        #1;
    endtask

    task automatic idle();
        we_0 = 1'b0; we_1 = 1'b0; rsv_en = 1'b0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("a_rdata_1", a_rd1, e.a1);
            chk("a_rdata_2", a_rd2, e.a2);
            chk("b_rdata_1", b_rd1, e.b1);
            chk("b_rdata_2", b_rd2, e.b2);
            chk("a_busy_1", {31'd0, a_bz1}, {31'd0, e.abz1});
            chk("a_busy_2", {31'd0, a_bz2}, {31'd0, e.abz2});
            chk("b_busy_1", {31'd0, b_bz1}, {31'd0, e.bbz1});
            chk("b_busy_2", {31'd0, b_bz2}, {31'd0, e.bbz2});
        end
    end

    function automatic logic [4:0] rnd_addr();
        return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
    endfunction

    initial begin
        clear_model();
        @(posedge clk); #1;
        // Reset state
        step(); step();
        reset = 1'b1; raddr_1 = 5'd5; step();

        // Reset mid-run after writing reg 5
        we_0 = 1'b1; waddr_0 = 5'd5; wdata_0 = 32'hDEADBEEF; step();
        idle(); step();
        reset = 1'b0; we_0 = 1'b1; waddr_0 = 5'd5; wdata_0 = 32'h12345678; step();
        idle(); step();
        reset = 1'b1; step(); step();

        // Same-address dual write
        raddr_1 = 5'd3;
        we_0 = 1'b1; waddr_0 = 5'd3; wdata_0 = 32'h11;
        we_1 = 1'b1; waddr_1 = 5'd3; wdata_1 = 32'h22; step();
        idle(); step();

        // Write to register 0
        raddr_2 = 5'd0; we_0 = 1'b1; waddr_0 = 5'd0; wdata_0 = 32'hFFFFFFFF; step();
        idle(); step();

        // Reserve then release register 8
        raddr_1 = 5'd8; rsv_en = 1'b1; rsv_addr = 5'd8; step();
        idle(); step();
        we_1 = 1'b1; waddr_1 = 5'd8; wdata_1 = 32'hA5A5A5A5; step();
        idle(); step();

        // Set and clear of the same register together
        rsv_en = 1'b1; rsv_addr = 5'd8; step();
        rsv_en = 1'b1; rsv_addr = 5'd8; we_0 = 1'b1; waddr_0 = 5'd8; wdata_0 = 32'h55; step();
        idle(); step();

        // Reservation of register 4
        raddr_2 = 5'd4; rsv_en = 1'b1; rsv_addr = 5'd4; step();
        idle(); step();
        rsv_en = 1'b1; rsv_addr = 5'd0; raddr_1 = 5'd0; step();
        idle(); step();

        // Randomized traffic with occasional mid-run resets
        for (int n = 0; n < 600; n++) begin
            reset    = ($urandom_range(0, 63) != 0);
            we_0     = 1'($urandom_range(0, 1));
            we_1     = 1'($urandom_range(0, 1));
            rsv_en   = ($urandom_range(0, 9) < 3);
            waddr_0  = rnd_addr();
            waddr_1  = rnd_addr();
            rsv_addr = rnd_addr();
            raddr_1  = rnd_addr();
            raddr_2  = rnd_addr();
            wdata_0  = $urandom;
            wdata_1  = $urandom;
            step();
        end
        reset = 1'b1; idle(); step();

        for (int t = 0; t < 5 && q.size() > 0; t++) @(negedge clk);
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries never compared, want 0", q.size());
        end
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
